hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter DIV_CYCLES, default 32, meaning EX-stage cycles a divide occupies (range 2..64).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports rs1_id, rs2_id  input  5 each  source registers of the instruction in ID.
REQ-005 SHALL have ports rs1_ex, rs2_ex  input  5 each  source registers of the instruction in EX.
REQ-006 SHALL have ports rd_ex (5), reg_write_ex (1), mem_read_ex (1), div_ex (1), branch_taken_ex (1)  input  destination register, write enable, load flag, divide flag and taken-branch/jump flag of the EX instruction.
REQ-007 SHALL have ports rd_mem (5), reg_write_mem (1)  input  destination register and write enable of the MEM instruction.
REQ-008 SHALL have ports rd_wb (5), reg_write_wb (1)  input  destination register and write enable of the WB instruction.
REQ-009 SHALL have ports forward_a_sel, forward_b_sel  output  forwardCtrl_e  operand selects for rs1_ex and rs2_ex, driving the EX operand muxes.
REQ-010 SHALL have ports stall_if, stall_id, stall_ex  output  1 each  hold the corresponding pipeline register.
REQ-011 SHALL have ports flush_id, flush_ex  output  1 each  load a bubble into the corresponding pipeline register.
REQ-012 SHALL have port div_done  output  1  one-cycle pulse in the final divide cycle.
REQ-013 SHALL have port stall_count  output  32  count of cycles with stall_if high.

Function
REQ-014 forward_a_sel SHALL be FORWARD_FROM_MEM if reg_write_mem, rd_mem != 0 and rd_mem == rs1_ex; else FORWARD_FROM_WB if reg_write_wb, rd_wb != 0 and rd_wb == rs1_ex; else FORWARD_NONE. This path is combinational with zero latency.
REQ-015 forward_b_sel SHALL follow REQ-014 using rs2_ex.
REQ-016 A load-use hazard SHALL be detected when mem_read_ex, reg_write_ex and rd_ex != 0 all hold, and rd_ex equals rs1_id or rs2_id.
REQ-017 The FSM SHALL have states IDLE, LOAD_STALL and DIV_BUSY, with all state registered.
REQ-018 IDLE -> DIV_BUSY SHALL occur when div_ex = 1 and branch_taken_ex = 0. The down-counter SHALL load DIV_CYCLES-2 and stall_if, stall_id and stall_ex SHALL assert in that same cycle.
REQ-019 In DIV_BUSY, stall_if, stall_id and stall_ex SHALL stay high and the counter SHALL decrement each cycle.
REQ-020 When the counter = 0 in DIV_BUSY, div_done SHALL pulse, all stalls SHALL deassert, and the next state SHALL be IDLE. Total divide occupancy is DIV_CYCLES cycles.
REQ-021 In DIV_BUSY, branch_taken_ex and load-use detection SHALL be ignored, and div_ex SHALL NOT restart the counter.
REQ-022 IDLE -> LOAD_STALL SHALL occur on load-use with no div_ex and no branch_taken_ex. In that cycle stall_if = stall_id = 1 and flush_ex = 1.
REQ-023 LOAD_STALL SHALL last exactly one cycle with all control outputs low, then return to IDLE. A repeated load-use in that cycle SHALL NOT be possible by construction and SHALL be ignored.
REQ-024 branch_taken_ex in IDLE SHALL assert flush_id = flush_ex = 1 for that cycle with no stall. Branch SHALL override load-use.
REQ-025 Priority SHALL be DIV_BUSY > branch flush > divide start > load-use.
REQ-026 Forward selects SHALL remain valid in every state, including while stalled.
REQ-027 stall_count SHALL increment by 1 on each cycle with stall_if = 1 and SHALL wrap from 0xFFFFFFFF to 0.
REQ-028 The counter width SHALL be 6 bits. DIV_CYCLES-2 SHALL fit this width.

Reset
REQ-029 While rst_n = 0, the FSM SHALL be IDLE, the counter 0 and stall_count 0.
REQ-030 While rst_n = 0, stalls, flushes and div_done SHALL be 0, and forward selects SHALL be FORWARD_NONE.
REQ-031 Reset asserted mid-divide or mid-stall SHALL abort the operation immediately, with no div_done pulse.

Verification
REQ-032 rs1_ex = 5, rd_mem = 5, reg_write_mem = 1, rd_wb = 5, reg_write_wb = 1 -> forward_a_sel = FORWARD_FROM_MEM. The same stimulus with rd_mem = 0 -> FORWARD_FROM_WB.
REQ-033 mem_read_ex = 1, reg_write_ex = 1, rd_ex = 7, rs2_id = 7 -> one cycle with stall_if = stall_id = flush_ex = 1, then all low. stall_count = 1.
REQ-034 div_ex = 1 in IDLE with DIV_CYCLES = 32 -> stalls high for exactly 32 cycles, div_done high only in the 32nd, then IDLE.
REQ-035 branch_taken_ex = 1 together with a load-use match -> flush_id = flush_ex = 1, stall_if = 0, state stays IDLE.
REQ-036 rst_n pulled low in divide cycle 10 -> outputs 0 asynchronously. After release, the FSM is IDLE, there is no div_done, and stall_count = 0.
REQ-037 rd_mem = 0 with reg_write_mem = 1, rs1_ex = 0 -> forward_a_sel = FORWARD_NONE.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX operand forwarding, load-use stall, multi-cycle
// divide stall and taken-branch flush for a five-stage in-order pipeline.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FORWARD_NONE     = 2'b00,
        FORWARD_FROM_MEM = 2'b01,
        FORWARD_FROM_WB  = 2'b10
    } forwardCtrl_e;

endpackage

module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [4:0]   rs1_id,
    input  logic [4:0]   rs2_id,
    input  logic [4:0]   rs1_ex,
    input  logic [4:0]   rs2_ex,
    input  logic [4:0]   rd_ex,
    input  logic         reg_write_ex,
    input  logic         mem_read_ex,
    input  logic         div_ex,
    input  logic         branch_taken_ex,
    input  logic [4:0]   rd_mem,
    input  logic         reg_write_mem,
    input  logic [4:0]   rd_wb,
    input  logic         reg_write_wb,
    output forwardCtrl_e forward_a_sel,
    output forwardCtrl_e forward_b_sel,
    output logic         stall_if,
    output logic         stall_id,
    output logic         stall_ex,
    output logic         flush_id,
    output logic         flush_ex,
    output logic         div_done,
    output logic [31:0]  stall_count
);

    if (DIV_CYCLES < 2 || DIV_CYCLES > 64) begin : g_bad_div_cycles
        $error("hazard_ctrl: DIV_CYCLES must be in 2..64");
    end

    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 2);

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        LOAD_STALL = 2'b01,
        DIV_BUSY   = 2'b10
    } state_e;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic flush_id;
        logic flush_ex;
        logic div_done;
    } ctrl_t;

    state_e       state;
    state_e       next_state;
    logic [5:0]   div_cnt;
    logic         cnt_load;
    logic         load_use;
    ctrl_t        ctrl;
    forwardCtrl_e fwd_a;
    forwardCtrl_e fwd_b;

    // MEM is the younger producer, so it wins over WB when both match.
    function automatic forwardCtrl_e fwd_sel(input logic [4:0] rs);
        if (reg_write_mem && rd_mem != 5'd0 && rd_mem == rs) return FORWARD_FROM_MEM;
        if (reg_write_wb && rd_wb != 5'd0 && rd_wb == rs)    return FORWARD_FROM_WB;
        return FORWARD_NONE;
    endfunction

    assign fwd_a = fwd_sel(rs1_ex);
    assign fwd_b = fwd_sel(rs2_ex);

    assign load_use = mem_read_ex && reg_write_ex && (rd_ex != 5'd0) &&
                      ((rd_ex == rs1_id) || (rd_ex == rs2_id));

    // Stalls must act in the same cycle the hazard is seen, so controls are
    // decoded from the registered state plus the current inputs.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        ctrl       = '0;
        next_state = state;
        cnt_load   = 1'b0;
        unique case (state)
            IDLE: begin
                if (branch_taken_ex) begin
                    ctrl.flush_id = 1'b1;
                    ctrl.flush_ex = 1'b1;
                end else if (div_ex) begin
                    ctrl.stall_if = 1'b1;
                    ctrl.stall_id = 1'b1;
                    ctrl.stall_ex = 1'b1;
                    cnt_load      = 1'b1;
                    next_state    = DIV_BUSY;
                end else if (load_use) begin
                    ctrl.stall_if = 1'b1;
                    ctrl.stall_id = 1'b1;
                    ctrl.flush_ex = 1'b1;
                    next_state    = LOAD_STALL;
                end
            end
            LOAD_STALL: next_state = IDLE;
            DIV_BUSY: begin
                ctrl.stall_if = 1'b1;
                ctrl.stall_id = 1'b1;
                ctrl.stall_ex = 1'b1;
                if (div_cnt == 6'd0) begin
                    ctrl.div_done = 1'b1;
                    next_state    = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Reset forces every output quiet immediately, independent of the clock.
    assign {stall_if, stall_id, stall_ex, flush_id, flush_ex, div_done} = rst_n ? ctrl : '0;
    assign forward_a_sel = rst_n ? fwd_a : FORWARD_NONE;
    assign forward_b_sel = rst_n ? fwd_b : FORWARD_NONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            div_cnt     <= '0;
            stall_count <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            state <= next_state;
            if (cnt_load) begin
                div_cnt <= DIV_LOAD;
            end else if (state == DIV_BUSY && div_cnt != 6'd0) begin
                div_cnt <= div_cnt - 6'd1;
            end
            if (ctrl.stall_if) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table for single-cycle decisions, then
// hand sequences for load-use, full divide and reset during a divide.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [4:0]   rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
    logic         reg_write_ex, mem_read_ex, div_ex, branch_taken_ex;
    logic         reg_write_mem, reg_write_wb;
    forwardCtrl_e forward_a_sel, forward_b_sel;
    logic         stall_if, stall_id, stall_ex, flush_id, flush_ex, div_done;
    logic [31:0]  stall_count;

    always #5 clk = ~clk;

    hazard_ctrl #(.DIV_CYCLES(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
        .rd_ex(rd_ex), .reg_write_ex(reg_write_ex), .mem_read_ex(mem_read_ex),
        .div_ex(div_ex), .branch_taken_ex(branch_taken_ex),
        .rd_mem(rd_mem), .reg_write_mem(reg_write_mem),
        .rd_wb(rd_wb), .reg_write_wb(reg_write_wb),
        .forward_a_sel(forward_a_sel), .forward_b_sel(forward_b_sel),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
        .flush_id(flush_id), .flush_ex(flush_ex), .div_done(div_done),
        .stall_count(stall_count)
    );

    typedef struct packed {
        logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex;
        logic       reg_write_ex, mem_read_ex, div_ex, branch_taken_ex;
        logic [4:0] rd_mem;
        logic       reg_write_mem;
        logic [4:0] rd_wb;
        logic       reg_write_wb;
    } in_t;

    typedef struct packed {
        forwardCtrl_e fa, fb;
        logic         si, sid, sex, fid, fex;
    } exp_t;

    typedef struct {
        string name;
        in_t   in;
        exp_t  exp;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   exp_sc = 0;
    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Argument order: rs1_id rs2_id rs1_ex rs2_ex rd_ex rw_ex mr_ex div br rd_mem rw_mem rd_wb rw_wb
    function automatic in_t mk_in(input int a, b, c, d, e, f, g, h, i, j, k, l, m);
        in_t v;
        v.rs1_id = 5'(a); v.rs2_id = 5'(b); v.rs1_ex = 5'(c); v.rs2_ex = 5'(d);
        v.rd_ex = 5'(e); v.reg_write_ex = 1'(f); v.mem_read_ex = 1'(g);
        v.div_ex = 1'(h); v.branch_taken_ex = 1'(i);
        v.rd_mem = 5'(j); v.reg_write_mem = 1'(k); v.rd_wb = 5'(l); v.reg_write_wb = 1'(m);
        return v;
    endfunction

    function automatic exp_t mk_exp(input forwardCtrl_e fa, fb, input int si, sid, sex, fid, fex);
        exp_t x;
        x.fa = fa; x.fb = fb;
        x.si = 1'(si); x.sid = 1'(sid); x.sex = 1'(sex); x.fid = 1'(fid); x.fex = 1'(fex);
        return x;
    endfunction

    task automatic drive(input in_t v);
        rs1_id = v.rs1_id; rs2_id = v.rs2_id; rs1_ex = v.rs1_ex; rs2_ex = v.rs2_ex;
        rd_ex = v.rd_ex; reg_write_ex = v.reg_write_ex; mem_read_ex = v.mem_read_ex;
        div_ex = v.div_ex; branch_taken_ex = v.branch_taken_ex;
        rd_mem = v.rd_mem; reg_write_mem = v.reg_write_mem;
        rd_wb = v.rd_wb; reg_write_wb = v.reg_write_wb;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic got_done;
        int   stall_hi, done_cnt, done_cyc, last_stall, flush_seen, sc0;

        vecs[0]  = '{"idle_zero",     mk_in(0,0,0,0,0,0,0,0,0,0,0,0,0),    mk_exp(FORWARD_NONE, FORWARD_NONE, 0,0,0,0,0)};
        vecs[1]  = '{"fwd_mem_prio",  mk_in(0,0,5,0,0,0,0,0,0,5,1,5,1),    mk_exp(FORWARD_FROM_MEM, FORWARD_NONE, 0,0,0,0,0)};
        vecs[2]  = '{"fwd_wb_rd0",    mk_in(0,0,5,0,0,0,0,0,0,0,1,5,1),    mk_exp(FORWARD_FROM_WB, FORWARD_NONE, 0,0,0,0,0)};
        vecs[3]  = '{"fwd_x0_none",   mk_in(0,0,0,0,0,0,0,0,0,0,1,0,1),    mk_exp(FORWARD_NONE, FORWARD_NONE, 0,0,0,0,0)};
        vecs[4]  = '{"fwd_b_wb",      mk_in(0,0,0,9,0,0,0,0,0,9,0,9,1),    mk_exp(FORWARD_NONE, FORWARD_FROM_WB, 0,0,0,0,0)};
        vecs[5]  = '{"fwd_ab_mem",    mk_in(0,0,3,3,0,0,0,0,0,3,1,0,0),    mk_exp(FORWARD_FROM_MEM, FORWARD_FROM_MEM, 0,0,0,0,0)};
        vecs[6]  = '{"lu_rs2",        mk_in(0,7,0,0,7,1,1,0,0,0,0,0,0),    mk_exp(FORWARD_NONE, FORWARD_NONE, 1,1,0,0,1)};
        vecs[7]  = '{"lu_rd0",        mk_in(0,0,0,0,0,1,1,0,0,0,0,0,0),    mk_exp(FORWARD_NONE, FORWARD_NONE, 0,0,0,0,0)};
        vecs[8]  = '{"lu_no_we",      mk_in(0,7,0,0,7,0,1,0,0,0,0,0,0),    mk_exp(FORWARD_NONE, FORWARD_NONE, 0,0,0,0,0)};
        vecs[9]  = '{"br_over_lu",    mk_in(0,7,0,0,7,1,1,0,1,0,0,0,0),    mk_exp(FORWARD_NONE, FORWARD_NONE, 0,0,0,1,1)};
        vecs[10] = '{"br_over_div",   mk_in(0,0,0,0,0,0,0,1,1,0,0,0,0),    mk_exp(FORWARD_NONE, FORWARD_NONE, 0,0,0,1,1)};
        vecs[11] = '{"lu_no_mread",   mk_in(12,0,0,0,12,1,0,0,0,0,0,0,0),  mk_exp(FORWARD_NONE, FORWARD_NONE, 0,0,0,0,0)};
        vecs[12] = '{"lu_rs1_fwd",    mk_in(2,0,6,0,2,1,1,0,0,0,0,6,1),    mk_exp(FORWARD_FROM_WB, FORWARD_NONE, 1,1,0,0,1)};

        // Reset with every hazard input active: all outputs must stay quiet.
        rst_n = 1'b0;
        drive(mk_in(0,7,5,0,7,1,1,1,1,5,1,5,1));
        #12;
        check("rst_fwd_a", 32'(forward_a_sel), 32'(FORWARD_NONE));
        check("rst_ctrl", {stall_if, stall_id, stall_ex, flush_id, flush_ex, div_done}, 0);
        check("rst_stall_count", stall_count, 0);
        @(negedge clk);
        drive('0);
        rst_n = 1'b1;

        foreach (vecs[n]) begin
            @(negedge clk);
            drive(vecs[n].in);
            #2;
            check({vecs[n].name, "_fa"}, 32'(forward_a_sel), 32'(vecs[n].exp.fa));
            check({vecs[n].name, "_fb"}, 32'(forward_b_sel), 32'(vecs[n].exp.fb));
            check({vecs[n].name, "_ctrl"}, {stall_if, stall_id, stall_ex, flush_id, flush_ex},
                  {vecs[n].exp.si, vecs[n].exp.sid, vecs[n].exp.sex, vecs[n].exp.fid, vecs[n].exp.fex});
            if (vecs[n].exp.si) exp_sc++;
            @(negedge clk);
            drive('0);
            #2;
            check({vecs[n].name, "_after"}, {stall_if, stall_ex, flush_id, flush_ex, div_done}, 0);
            check({vecs[n].name, "_count"}, stall_count, exp_sc);
        end

        // Load-use held into the bubble cycle must not retrigger.
        @(negedge clk);
        drive(mk_in(0,7,0,0,7,1,1,0,0,0,0,0,0));
        #2;
        check("lu_seq_first", {stall_if, stall_id, stall_ex, flush_id, flush_ex}, 5'b11001);
        @(negedge clk);
        #2;
        check("lu_seq_bubble", {stall_if, stall_id, stall_ex, flush_id, flush_ex}, 0);
        @(negedge clk);
        drive('0);
        exp_sc++;
        #2;
        check("lu_seq_count", stall_count, exp_sc);

        // Full divide; branch, load-use and div_ex stay asserted while busy.
        sc0 = exp_sc;
        stall_hi = 0; done_cnt = 0; done_cyc = 0; last_stall = 0; flush_seen = 0;
        @(negedge clk);
        drive(mk_in(0,0,0,0,0,0,0,1,0,0,0,0,0));
        for (int c = 1; c <= 40; c++) begin
            #2;
            got_done = div_done;
            if (stall_if && stall_id && stall_ex) begin
                stall_hi++;
                last_stall = c;
            end
            if (div_done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (flush_id || flush_ex) flush_seen++;
            if (c == 10) check("div_fwd_while_busy", 32'(forward_a_sel), 32'(FORWARD_FROM_MEM));
            @(negedge clk);
            if (got_done) drive('0);
            else if (c == 1) drive(mk_in(7,0,4,0,7,1,1,1,1,4,1,0,0));
        end
        drive('0);
        exp_sc += 32;
        check("div_stall_cycles", stall_hi, 32);
        check("div_last_stall", last_stall, 32);
        check("div_done_pulses", done_cnt, 1);
        check("div_done_cycle", done_cyc, 32);
        check("div_no_flush", flush_seen, 0);
        #2;
        check("div_count", stall_count, exp_sc);

        // Reset in divide cycle 10 aborts the divide without a done pulse.
        @(negedge clk);
        drive(mk_in(0,0,0,0,0,0,0,1,0,0,0,0,0));
        repeat (9) @(negedge clk);
        drive(mk_in(0,0,5,0,0,0,0,1,1,5,1,0,0));
        #2;
        check("rstdiv_pre_stall", stall_if, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstdiv_ctrl", {stall_if, stall_id, stall_ex, flush_id, flush_ex, div_done}, 0);
        check("rstdiv_fwd_a", 32'(forward_a_sel), 32'(FORWARD_NONE));
        check("rstdiv_count", stall_count, 0);
        @(negedge clk);
        drive('0);
        rst_n = 1'b1;
        done_cnt = 0; stall_hi = 0;
        for (int c = 0; c < 40; c++) begin
            #2;
            if (div_done) done_cnt++;
            if (stall_if) stall_hi++;
            @(negedge clk);
        end
        check("rstdiv_no_done", done_cnt, 0);
        check("rstdiv_idle", stall_hi, 0);
        check("rstdiv_count_after", stall_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
